// File: rtl/bf_pkg.sv
// bf_pkg
// Shared types for the Brainfuck interpreter cores.
//   BusOp       : operation code on the shared req/ack bus (also used by the
//                 first-generation core, so the encoding must not change)
//   BfCoreState : core FSM state, exported on the debug port
//   BfFault     : latched fault reason
// Also holds the instruction byte encodings and a helper that tells which
// states own the bus.
package bf_pkg;

  typedef enum logic [2:0] {
    BusNone      = 3'd0,
    BusReadProg  = 3'd1,
    BusReadData  = 3'd2,
    BusWriteData = 3'd3,
    BusReadIo    = 3'd4,
    BusWriteIo   = 3'd5
  } BusOp;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    EXEC    = 4'd1,
    RD_CELL = 4'd2,
    ACT     = 4'd3,
    RD_IO   = 4'd4,
    WR_CELL = 4'd5,
    WR_IO   = 4'd6,
    SKIP    = 4'd7,
    HALT    = 4'd8,
    FAULT   = 4'd9
  } BfCoreState;

  typedef enum logic [1:0] {
    FaultNone           = 2'd0,
    FaultOverflow       = 2'd1,
    FaultUnmatchedClose = 2'd2,
    FaultUnmatchedOpen  = 2'd3
  } BfFault;

  // Instruction byte encodings (ASCII)
  localparam logic [7:0] OP_INC   = 8'h2B;  // +
  localparam logic [7:0] OP_IN    = 8'h2C;  // ,
  localparam logic [7:0] OP_DEC   = 8'h2D;  // -
  localparam logic [7:0] OP_OUT   = 8'h2E;  // .
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // >
  localparam logic [7:0] OP_OPEN  = 8'h5B;  // [
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ]
  localparam logic [7:0] OP_NUL   = 8'h00;

  // States in which the core drives a bus transaction.
  function automatic logic is_bus_state(input BfCoreState s);
    return (s == FETCH) || (s == RD_CELL) || (s == RD_IO) ||
           (s == WR_CELL) || (s == WR_IO) || (s == SKIP);
  endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// bf_loop_stack
// LIFO of loop-start program addresses. The entry on top is the address of
// the instruction following the innermost open '['.
// Ports:
//   clock, reset : clock and asynchronous active-high reset (empties stack)
//   push, pop    : push din / discard top; never asserted together
//   din          : address to push
//   top          : current top entry (undefined when empty)
//   full, empty  : occupancy flags
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int STACK_DEPTH     = 16,
  parameter int PROG_ADDR_WIDTH = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PROG_ADDR_WIDTH-1:0] din,
  output logic [PROG_ADDR_WIDTH-1:0] top,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_WIDTH   = $clog2(STACK_DEPTH);
  localparam int COUNT_WIDTH = $clog2(STACK_DEPTH + 1);

  logic [PROG_ADDR_WIDTH-1:0] entries [STACK_DEPTH];
  logic [COUNT_WIDTH-1:0]     count;
  logic [COUNT_WIDTH-1:0]     top_count;
  logic [PTR_WIDTH-1:0]       top_idx;
  logic [PTR_WIDTH-1:0]       push_idx;

  assign full      = (count == COUNT_WIDTH'(STACK_DEPTH));
  assign empty     = (count == '0);
  // Guard the empty case so the top index never underflows.
  assign top_count = empty ? '0 : (count - COUNT_WIDTH'(1));
  assign top_idx   = top_count[PTR_WIDTH-1:0];
  assign push_idx  = count[PTR_WIDTH-1:0];
  assign top       = entries[top_idx];

  // Occupancy counter; overflowing pushes and underflowing pops are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + COUNT_WIDTH'(1);
    end else if (pop && !empty) begin
      count <= count - COUNT_WIDTH'(1);
    end
  end

  // Entry storage needs no reset: only entries below count are ever read
  always_ff @(posedge clock) begin
    if (push && !full) begin
      entries[push_idx] <= din;
    end
  end

endmodule

// File: rtl/bf_core_stack.sv
// bf_core_stack
// Brainfuck interpreter core with a hardware loop-address stack, so a taken
// ']' jumps straight back instead of scanning the program backwards. All
// program, data and I/O traffic goes over one req/ack bus.
// Ports:
//   clock, reset     : clock and asynchronous active-high reset
//   enable           : run (1) / stall (0)
//   bus_req, bus_op  : transaction request and its operation
//   bus_addr         : zero-extended pc or cursor; 0 for I/O
//   bus_wdata        : zero-extended cell value for writes
//   bus_rdata        : read data, sampled in the ack cycle
//   bus_ack          : transaction completes on a clock edge with req & ack
//   halted           : NUL executed, core idle until reset
//   fault, fault_code: fault latched, core idle until reset
//   state            : FSM state for debug
module bf_core_stack
  import bf_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH  = 15,
  parameter int DATA_ADDR_WIDTH  = 15,
  parameter int ADDR_WIDTH       = 15,
  parameter int CELL_WIDTH       = 8,
  parameter int BUS_WIDTH        = 8,
  parameter int STACK_DEPTH      = 16,
  parameter int SKIP_DEPTH_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  bus_req,
  output BusOp                  bus_op,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [BUS_WIDTH-1:0]  bus_wdata,
  input  logic [BUS_WIDTH-1:0]  bus_rdata,
  input  logic                  bus_ack,
  output logic                  halted,
  output logic                  fault,
  output BfFault                fault_code,
  output BfCoreState            state
);

  logic [PROG_ADDR_WIDTH-1:0]  pc;
  logic [DATA_ADDR_WIDTH-1:0]  cursor;
  logic [CELL_WIDTH-1:0]       acc;
  logic [7:0]                  instr;
  logic [SKIP_DEPTH_WIDTH-1:0] skip_depth;
  logic                        txn_open;

  logic                        in_bus_state;
  logic                        bus_fire;
  logic                        acc_zero;
  logic                        act_step;

  logic                        stk_push;
  logic                        stk_pop;
  logic [PROG_ADDR_WIDTH-1:0]  stk_top;
  logic                        stk_full;
  logic                        stk_empty;

  assign in_bus_state = is_bus_state(state);
  assign bus_fire     = bus_req & bus_ack;
  assign acc_zero     = (acc == '0);
  assign act_step     = (state == ACT) && enable;

  // A taken '[' pushes the address after itself (pc already advanced at
  // fetch). An exiting ']' pops; a taken ']' only reads the top.
  assign stk_push = act_step && (instr == OP_OPEN) && !acc_zero && !stk_full;
  assign stk_pop  = act_step && (instr == OP_CLOSE) && acc_zero && !stk_empty;

  bf_loop_stack #(
    .STACK_DEPTH    (STACK_DEPTH),
    .PROG_ADDR_WIDTH(PROG_ADDR_WIDTH)
  ) u_loop_stack (
    .clock(clock),
    .reset(reset),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (pc),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

  // Bus outputs are decoded from the state and registers that cannot change
  // until ack, so they hold steady across wait states. Once a request has
  // been seen without ack (txn_open), it stays up even if enable drops.
  always_comb begin
    bus_req   = 1'b0;
    bus_op    = BusNone;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      FETCH, SKIP: begin
        bus_op   = BusReadProg;
        bus_addr = ADDR_WIDTH'(pc);
      end
      RD_CELL: begin
        bus_op   = BusReadData;
        bus_addr = ADDR_WIDTH'(cursor);
      end
      WR_CELL: begin
        bus_op    = BusWriteData;
        bus_addr  = ADDR_WIDTH'(cursor);
        bus_wdata = BUS_WIDTH'(acc);
      end
      RD_IO: begin
        bus_op = BusReadIo;
      end
      WR_IO: begin
        bus_op    = BusWriteIo;
        bus_wdata = BUS_WIDTH'(acc);
      end
      default: ;
    endcase
    if (in_bus_state) begin
      bus_req = enable | txn_open;
    end
  end

  // Main FSM. Bus states move on ack; other states move only when enabled.
  // HALT and FAULT are terminal until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      cursor     <= '0;
      acc        <= '0;
      instr      <= '0;
      skip_depth <= '0;
      txn_open   <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FaultNone;
    end else begin
      if (in_bus_state) begin
        txn_open <= bus_req & ~bus_ack;
      end else begin
        txn_open <= 1'b0;
      end

      case (state)
        FETCH: begin
          if (bus_fire) begin
            instr <= bus_rdata[7:0];
            pc    <= pc + PROG_ADDR_WIDTH'(1);
            state <= EXEC;
          end
        end

        EXEC: begin
          if (enable) begin
            case (instr)
              OP_INC, OP_DEC, OP_OUT, OP_OPEN, OP_CLOSE: state <= RD_CELL;
              OP_IN: state <= RD_IO;
              OP_RIGHT: begin
                cursor <= cursor + DATA_ADDR_WIDTH'(1);
                state  <= FETCH;
              end
              OP_LEFT: begin
                cursor <= cursor - DATA_ADDR_WIDTH'(1);
                state  <= FETCH;
              end
              OP_NUL: begin
                halted <= 1'b1;
                state  <= HALT;
              end
              default: state <= FETCH;
            endcase
          end
        end

        RD_CELL: begin
          if (bus_fire) begin
            acc   <= bus_rdata[CELL_WIDTH-1:0];
            state <= ACT;
          end
        end

        ACT: begin
          if (enable) begin
            case (instr)
              OP_INC: begin
                acc   <= acc + CELL_WIDTH'(1);
                state <= WR_CELL;
              end
              OP_DEC: begin
                acc   <= acc - CELL_WIDTH'(1);
                state <= WR_CELL;
              end
              OP_OUT: state <= WR_IO;
              OP_OPEN: begin
                if (acc_zero) begin
                  skip_depth <= '0;
                  state      <= SKIP;
                end else if (stk_full) begin
                  fault      <= 1'b1;
                  fault_code <= FaultOverflow;
                  state      <= FAULT;
                end else begin
                  state <= FETCH;
                end
              end
              OP_CLOSE: begin
                // An empty stack is a fault whatever the cell holds.
                if (stk_empty) begin
                  fault      <= 1'b1;
                  fault_code <= FaultUnmatchedClose;
                  state      <= FAULT;
                end else begin
                  if (!acc_zero) begin
                    pc <= stk_top;
                  end
                  state <= FETCH;
                end
              end
              default: state <= FETCH;
            endcase
          end
        end

        RD_IO: begin
          if (bus_fire) begin
            acc   <= bus_rdata[CELL_WIDTH-1:0];
            state <= WR_CELL;
          end
        end

        WR_CELL, WR_IO: begin
          if (bus_fire) begin
            state <= FETCH;
          end
        end

        // Forward scan to the matching ']', counting nested brackets.
        SKIP: begin
          if (bus_fire) begin
            pc <= pc + PROG_ADDR_WIDTH'(1);
            case (bus_rdata[7:0])
              OP_OPEN: begin
                if (skip_depth == '1) begin
                  fault      <= 1'b1;
                  fault_code <= FaultOverflow;
                  state      <= FAULT;
                end else begin
                  skip_depth <= skip_depth + SKIP_DEPTH_WIDTH'(1);
                end
              end
              OP_CLOSE: begin
                if (skip_depth == '0) begin
                  state <= FETCH;
                end else begin
                  skip_depth <= skip_depth - SKIP_DEPTH_WIDTH'(1);
                end
              end
              OP_NUL: begin
                fault      <= 1'b1;
                fault_code <= FaultUnmatchedOpen;
                state      <= FAULT;
              end
              default: ;
            endcase
          end
        end

        HALT, FAULT: ;

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_core_stack.sv
// tb_bf_core_stack
// Runs short Brainfuck programs through bf_core_stack against a simple
// memory/IO slave. Expected I/O output bytes are queued when a program is
// launched; a monitor process pops and compares each WriteIo the slave sees.
module tb_bf_core_stack;
  import bf_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        bus_req;
  BusOp        bus_op;
  logic [14:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        halted;
  logic        fault;
  BfFault      fault_code;
  BfCoreState  state;

  int checks = 0;
  int errors = 0;

  logic [7:0] pmem [256];
  logic [7:0] dmem [256];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  event       io_ev;

  bit         wait_mode = 1'b0;
  bit         toggle_en = 1'b0;
  bit         run_en    = 1'b0;
  logic [7:0] io_in     = 8'h00;
  int         cycles;

  bf_core_stack #(
    .STACK_DEPTH(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .bus_req   (bus_req),
    .bus_op    (bus_op),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code),
    .state     (state)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Enable driver: follows run_en, or a random pattern while toggling
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      enable = toggle_en ? ($urandom_range(0, 2) != 0) : run_en;
    end
  end

  // Bus slave: decides acks at negedge, records completions one negedge
  // later, and checks the request stays unchanged between req and ack
  initial begin
    logic       req_q;
    logic       outstanding;
    int         wait_left;
    BusOp       cap_op;
    logic [14:0] cap_addr;
    logic [7:0] cap_wdata;
    logic       stable_ok;
    bus_ack     = 1'b0;
    bus_rdata   = 8'h00;
    req_q       = 1'b0;
    outstanding = 1'b0;
    wait_left   = 0;
    cap_op      = BusNone;
    cap_addr    = '0;
    cap_wdata   = '0;
    stable_ok   = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus_ack     = 1'b0;
        req_q       = 1'b0;
        outstanding = 1'b0;
      end else begin
        if (bus_ack && req_q) begin
          checkOutput("bus_stable", stable_ok, 1);
          case (cap_op)
            BusWriteData: dmem[cap_addr[7:0]] = cap_wdata;
            BusWriteIo: begin
              obs_q.push_back(cap_wdata);
              -> io_ev;
            end
            default: ;
          endcase
          outstanding = 1'b0;
        end
        req_q = bus_req;
        if (bus_req) begin
          if (!outstanding) begin
            outstanding = 1'b1;
            cap_op      = bus_op;
            cap_addr    = bus_addr;
            cap_wdata   = bus_wdata;
            stable_ok   = 1'b1;
            wait_left   = wait_mode ? int'($urandom_range(0, 3)) : 0;
          end else if (bus_op != cap_op || bus_addr != cap_addr ||
                       bus_wdata != cap_wdata) begin
            stable_ok = 1'b0;
          end
          if (wait_left == 0) begin
            bus_ack = 1'b1;
            case (bus_op)
              BusReadProg: bus_rdata = pmem[bus_addr[7:0]];
              BusReadData: bus_rdata = dmem[bus_addr[7:0]];
              BusReadIo:   bus_rdata = io_in;
              default:     bus_rdata = 8'h00;
            endcase
          end else begin
            wait_left--;
            bus_ack = 1'b0;
          end
        end else begin
          bus_ack = 1'b0;
        end
      end
    end
  end

  // Output monitor: pairs each observed output byte with the next expectation
  initial begin
    logic [7:0] got;
    forever begin
      @(io_ev);
      while (obs_q.size() > 0) begin
        got = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, expected none", got);
        end else begin
          checkOutput("io_output", got, exp_q.pop_front());
        end
      end
    end
  end

  // Reset the core, load a program, release and run until halt/fault
  task automatic applyStimulus(input string prog, input logic [7:0] in_byte,
                               input bit waits, input bit toggle);
    @(posedge clock);
    #3;
    run_en    = 1'b0;
    toggle_en = 1'b0;
    reset     = 1'b1;
    @(posedge clock);
    #3;
    checkOutput("reset_state", int'(state), int'(FETCH));
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_fault", fault, 0);
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 8'h00;
      dmem[i] = 8'h00;
    end
    for (int i = 0; i < prog.len(); i++) begin
      pmem[i] = prog[i];
    end
    io_in     = in_byte;
    wait_mode = waits;
    run_en    = 1'b1;
    toggle_en = toggle;
    @(posedge clock);
    #3;
    reset  = 1'b0;
    cycles = 0;
    while (!halted && !fault && cycles < 3000) begin
      @(posedge clock);
      cycles++;
      #1;
    end
    checkOutput("run_bounded", (cycles < 3000), 1);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("outputs_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // +++. : 4 x 5 cycles + NUL fetch/exec
    exp_q.push_back(8'h03);
    applyStimulus("+++.", 8'h00, 1'b0, 1'b0);
    checkOutput("p1_halted", halted, 1);
    checkOutput("p1_cycles", cycles, 22);
    checkOutput("p1_bus_req", bus_req, 0);

    // two iterations: 10 + 4 + 2*(24+4) + 2 + 5 + 2
    exp_q.push_back(8'h06);
    applyStimulus("++[>+++<-]>.", 8'h00, 1'b0, 1'b0);
    checkOutput("p2_halted", halted, 1);
    checkOutput("p2_cycles", cycles, 79);
    checkOutput("p2_stack_empty", dut.u_loop_stack.empty, 1);
    checkOutput("p2_cell1", dmem[1], 8'h06);

    // skipped loop: 4 + 6 skipped bytes, then '-' wraps to 0xFF
    exp_q.push_back(8'hFF);
    applyStimulus("[+[+]+]-.", 8'h00, 1'b0, 1'b0);
    checkOutput("p3_halted", halted, 1);
    checkOutput("p3_cycles", cycles, 22);

    // comment, cursor moves, two outputs
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    applyStimulus("a>++<+.>.", 8'h00, 1'b0, 1'b0);
    checkOutput("p4_halted", halted, 1);
    checkOutput("p4_cycles", cycles, 35);

    // input then increment
    exp_q.push_back(8'h42);
    applyStimulus(",+.", 8'h41, 1'b0, 1'b0);
    checkOutput("p5_halted", halted, 1);
    checkOutput("p5_cell0", dmem[0], 8'h42);

    // loop stack overflow with two entries
    applyStimulus("+[[[", 8'h00, 1'b0, 1'b0);
    checkOutput("p6_fault", fault, 1);
    checkOutput("p6_code", int'(fault_code), 1);
    checkOutput("p6_bus_req", bus_req, 0);
    checkOutput("p6_halted", halted, 0);

    applyStimulus("]", 8'h00, 1'b0, 1'b0);
    checkOutput("p7_fault", fault, 1);
    checkOutput("p7_code", int'(fault_code), 2);

    applyStimulus("[", 8'h00, 1'b0, 1'b0);
    checkOutput("p8_fault", fault, 1);
    checkOutput("p8_code", int'(fault_code), 3);

    // same programs with wait states and enable toggling
    exp_q.push_back(8'h06);
    applyStimulus("++[>+++<-]>.", 8'h00, 1'b1, 1'b1);
    checkOutput("p9_halted", halted, 1);
    checkOutput("p9_stack_empty", dut.u_loop_stack.empty, 1);

    exp_q.push_back(8'hFF);
    applyStimulus("[+[+]+]-.", 8'h00, 1'b1, 1'b1);
    checkOutput("p10_halted", halted, 1);

    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    applyStimulus("a>++<+.>.", 8'h00, 1'b1, 1'b1);
    checkOutput("p11_halted", halted, 1);

    exp_q.push_back(8'h42);
    applyStimulus(",+.", 8'h41, 1'b1, 1'b1);
    checkOutput("p12_halted", halted, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
